// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated output multiplexer.
// Mode encodings match the ones used by the datapath 2:1 selects.
package arb_mux_pkg;

    localparam logic MUX_MODE_SEL = 1'b0;
    localparam logic MUX_MODE_RR  = 1'b1;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at the pointer and owns the pointer,
// which moves one past the winner whenever the caller reports an accepted grant.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            adv,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    logic [SELW-1:0] ptr_reg;
    logic [SELW-1:0] grant_next;
    logic            found;
    logic [SELW-1:0] idx;
    int              pos;

    // Index arithmetic is done in int so the wrap is at N, not at 2**SELW.
    always_comb begin
        grant_next = ptr_reg;
        found      = 1'b0;
        idx        = '0;
        pos        = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_reg) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = SELW'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_next = idx;
            end
        end
    end

    assign grant     = grant_next;
    assign grant_vld = |req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (adv) begin
            ptr_reg <= (grant_next == SELW'(N - 1)) ? '0 : grant_next + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered multiplexer with valid/ready on every input and the output.
// Direct-select or round-robin grant feeds a single output register stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_ch_reg;

    logic [SELW-1:0]  rr_grant;
    logic             rr_grant_vld;
    logic             sel_vld;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] data_sel;

    rr_arbiter #(.N(N)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .adv       (xfer && (mode == MUX_MODE_RR)),
        .grant     (rr_grant),
        .grant_vld (rr_grant_vld)
    );

    // Comparing against every legal index makes an out-of-range sel yield no grant.
    always_comb begin
        sel_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                sel_vld = in_valid[i];
            end
        end
    end

    assign grant     = (mode == MUX_MODE_RR) ? rr_grant     : sel;
    assign grant_vld = (mode == MUX_MODE_RR) ? rr_grant_vld : sel_vld;
    assign load_en   = !out_valid_reg || out_ready;
    assign xfer      = load_en && grant_vld;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = xfer && (grant == SELW'(gi));
        end
    endgenerate

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                data_sel = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_sel;
            out_ch_reg    <= grant;
        end else if (load_en) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: reset, direct select, round-robin order and wrap,
// backpressure, plus a 5-channel instance for the out-of-range select case.
module tb_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int N5    = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [1:0]         sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_ch;
    logic               out_ready;

    logic [2:0]          sel5;
    logic [N5-1:0]       in_valid5;
    logic [N5*WIDTH-1:0] in_data5;
    logic [N5-1:0]       in_ready5;
    logic                out_valid5;
    logic [WIDTH-1:0]    out_data5;
    logic [2:0]          out_ch5;
    logic                out_ready5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    arb_mux #(.WIDTH(WIDTH), .N(N5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b0),
        .sel       (sel5),
        .in_valid  (in_valid5),
        .in_data   (in_data5),
        .in_ready  (in_ready5),
        .out_valid (out_valid5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_ready (out_ready5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = '0;
        out_ready  = 1'b0;
        sel5       = 3'd0;
        in_valid5  = '0;
        out_ready5 = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hC0DE_0000 + i;
        for (int i = 0; i < N5; i++) in_data5[i*WIDTH +: WIDTH] = 32'hC0DE_0000 + i;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ptr", 64'(dut.u_rr.ptr_reg), 64'd0);

        // 1: async reset while holding a word under backpressure
        sel = 2'd1; in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        chk("t1_load_vld", 64'(out_valid), 64'd1);
        chk("t1_load_data", 64'(out_data), 64'hC0DE_0001);
        rst_n = 1'b0;
        #1;
        chk("t1_async_vld", 64'(out_valid), 64'd0);
        chk("t1_async_data", 64'(out_data), 64'd0);
        chk("t1_async_ch", 64'(out_ch), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t1_ptr", 64'(dut.u_rr.ptr_reg), 64'd0);

        // 2: direct select
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        #1;
        chk("t2_in_ready", 64'(in_ready), 64'b0100);
        tick();
        chk("t2_vld", 64'(out_valid), 64'd1);
        chk("t2_data", 64'(out_data), 64'hDEADBEEF);
        chk("t2_ch", 64'(out_ch), 64'd2);
        in_data[2*WIDTH +: WIDTH] = 32'hC0DE_0002;

        // 3: direct select of an idle channel drains the output
        sel = 2'd1; in_valid = 4'b1101;
        #1;
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("t3_vld", 64'(out_valid), 64'd0);
        chk("t3_data_hold", 64'(out_data), 64'hDEADBEEF);
        chk("t3_ch_hold", 64'(out_ch), 64'd2);
        chk("t3_ptr_mode0", 64'(dut.u_rr.ptr_reg), 64'd0);
        sel5 = 3'd5; in_valid5 = 5'b11111;
        #1;
        chk("t3_sel_oor", 64'(in_ready5), 64'd0);
        sel5 = 3'd4;
        #1;
        chk("t3_sel_last", 64'(in_ready5), 64'b10000);
        tick();
        chk("t3_n5_ch", 64'(out_ch5), 64'd4);
        sel5 = 3'd5;
        tick();
        chk("t3_n5_drain", 64'(out_valid5), 64'd0);

        // 4: round-robin fairness, one word per clock
        mode = 1'b1; in_valid = 4'b1111;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t4_ch%0d", k), 64'(out_ch), 64'(k % 4));
            chk($sformatf("t4_vld%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("t4_data%0d", k), 64'(out_data), 64'hC0DE_0000 + 64'(k % 4));
        end
        chk("t4_ptr", 64'(dut.u_rr.ptr_reg), 64'd2);

        // 5: skip and wrap; first steer ptr to 1 via a lone ch0 request
        in_valid = 4'b0001;
        tick();
        chk("t5_pre_ch", 64'(out_ch), 64'd0);
        chk("t5_ptr1", 64'(dut.u_rr.ptr_reg), 64'd1);
        in_valid = 4'b1001;
        #1;
        chk("t5_rdy_a", 64'(in_ready), 64'b1000);
        tick();
        chk("t5_ch3", 64'(out_ch), 64'd3);
        chk("t5_ptr0", 64'(dut.u_rr.ptr_reg), 64'd0);
        chk("t5_rdy_b", 64'(in_ready), 64'b0001);
        tick();
        chk("t5_ch0", 64'(out_ch), 64'd0);
        chk("t5_ptr1b", 64'(dut.u_rr.ptr_reg), 64'd1);

        // 6: backpressure holds everything, release refills same cycle
        in_valid = 4'b1111;
        #1;
        chk("t6_rdy_pre", 64'(in_ready), 64'b0010);
        tick();
        chk("t6_ch1", 64'(out_ch), 64'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t6_rdy%0d", k), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("t6_data%0d", k), 64'(out_data), 64'hC0DE_0001);
            chk($sformatf("t6_vld%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("t6_ptr%0d", k), 64'(dut.u_rr.ptr_reg), 64'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("t6_rdy_rel", 64'(in_ready), 64'b0100);
        tick();
        chk("t6_ch2", 64'(out_ch), 64'd2);
        chk("t6_data2", 64'(out_data), 64'hC0DE_0002);
        chk("t6_ptr3", 64'(dut.u_rr.ptr_reg), 64'd3);

        in_valid = 4'b0000;
        tick();
        chk("end_drain", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
